clk_period_meter: RTL and testbench
===================================

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 Parameter CNT_W, default 16, width of period/high counters and result outputs.
REQ-002 Parameter SYNC_STAGES, default 2 (min 2), number of synchronizer flops on sig_in.
REQ-003 clk  input  1  system clock, rising edge active.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sig_in  input  1  signal under measurement (divided clock), asynchronous to clk.
REQ-006 start  input  1  one-cycle request to begin a measurement.
REQ-007 num_periods  input  4  number of sig_in periods to accumulate; sampled on accepted start.
REQ-008 busy  output  1  high from accepted start until the cycle after valid.
REQ-009 valid  output  1  one-cycle pulse: results updated.
REQ-010 period_cnt  output  CNT_W  clk cycles spanned by the measured periods.
REQ-011 high_cnt  output  CNT_W  clk cycles within the window where synchronized sig_in was high.
REQ-012 err  output  1  measurement failed (timeout/overflow); valid with results.

Function
REQ-013 sig_in SHALL pass through SYNC_STAGES flops; sample s = last stage output; s_d = s delayed one clk; rise = s & ~s_d.
REQ-014 FSM states SHALL be IDLE, WAIT_EDGE, MEASURE, DONE.
REQ-015 IDLE: start=1 -> WAIT_EDGE, latch N = num_periods (0 treated as 1), clear cycle counter, busy=1.
REQ-016 start while busy (any state but IDLE) SHALL be ignored; latched N unaffected.
REQ-017 WAIT_EDGE: counter increments each cycle; rise -> MEASURE with tot=0, hi=0, seen=0.
REQ-018 MEASURE: every cycle tot+=1, hi+=1 if s=1 in that cycle; rise increments seen.
REQ-019 Window = MEASURE cycles after the starting rise up to and including the cycle of the N-th further rise.
REQ-020 On the N-th rise, period_cnt<=tot+1 and high_cnt<=hi+s (terminating cycle included), err<=0, -> DONE.
REQ-021 Example: 50% sig_in of period 4 clk, N=1 -> period_cnt=4, high_cnt=2.
REQ-022 Timeout: counter in WAIT_EDGE reaching 2^CNT_W-1 without rise -> DONE, err=1, period_cnt=all ones, high_cnt=0.
REQ-023 Overflow: tot reaching 2^CNT_W-1 in MEASURE before completion -> DONE, err=1, period_cnt=all ones, high_cnt=hi saturated at all ones.
REQ-024 Counters SHALL saturate, never wrap.
REQ-025 DONE: valid=1 for exactly one cycle, then IDLE; busy deasserts in IDLE.
REQ-026 period_cnt, high_cnt, err SHALL hold between valid pulses.
REQ-027 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle accepted.
REQ-028 sig_in frequency above clk/2 is out of scope; result then undefined but FSM SHALL still terminate via REQ-022/023.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, busy=0, valid=0, err=0, period_cnt=0, high_cnt=0, all synchronizer/edge flops and counters to 0.
REQ-030 Reset mid-measurement SHALL discard partial counts; no valid pulse after release until a new start.
REQ-031 A sig_in already high when reset releases SHALL NOT produce a spurious rise from reset state beyond a real 0->1 of s.

Verification
REQ-032 sig_in = 50% divide-by-4 of clk, num_periods=1, start -> valid once, period_cnt=4, high_cnt=2, err=0.
REQ-033 sig_in = divide-by-6, num_periods=4 -> period_cnt=24, high_cnt=12, err=0; busy high start..valid.
REQ-034 CNT_W=8, sig_in stuck 0, start -> valid after 255 WAIT_EDGE cycles, err=1, period_cnt=255, high_cnt=0.
REQ-035 num_periods=0 with divide-by-4 -> period_cnt=4; second start pulses while busy -> exactly one valid.
REQ-036 Divide-by-3 50% (pos/neg-edge) source, num_periods=8 -> period_cnt=24, 8<=high_cnt<=16, err=0.
REQ-037 rst_n pulsed low mid-MEASURE -> all outputs 0 immediately, no valid; fresh start then gives REQ-032 result.

Source files
------------

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures span and high time of N periods of an asynchronous
// divided clock, in clk cycles, with saturating counters and timeout/overflow error.
module clk_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    input  logic [3:0]       num_periods,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             err
);
    localparam logic [CNT_W-1:0] MAX    = '1;
    localparam logic [CNT_W-1:0] ONE    = 1;
    localparam logic [CNT_W-1:0] MAX_M1 = MAX - ONE;

    typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, DONE} state_t;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s, s_d, rise;
    logic [3:0]             n, n_nx, seen, seen_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx, cnt_inc, hi, hi_nx, hi_s, period_nx, high_nx;
    logic                   err_nx;

    assign s       = sync[SYNC_STAGES-1];
    assign rise    = s & ~s_d;
    assign cnt_inc = (cnt == MAX) ? cnt : cnt + ONE;
    assign hi_s    = (s && hi != MAX) ? hi + ONE : hi;
    assign busy    = state != IDLE;
    assign valid   = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sync       <= '0;
            s_d        <= 1'b0;
            n          <= '0;
            seen       <= '0;
            cnt        <= '0;
            hi         <= '0;
            period_cnt <= '0;
            high_cnt   <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            sync       <= {sync[SYNC_STAGES-2:0], sig_in};
            s_d        <= s;
            n          <= n_nx;
            seen       <= seen_nx;
            cnt        <= cnt_nx;
            hi         <= hi_nx;
            period_cnt <= period_nx;
            high_cnt   <= high_nx;
            err        <= err_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        n_nx      = n;
        seen_nx   = seen;
        cnt_nx    = cnt;
        hi_nx     = hi;
        period_nx = period_cnt;
        high_nx   = high_cnt;
        err_nx    = err;
        case (state)
            IDLE: if (start) begin
                state_nx = WAIT_EDGE;
                n_nx     = (num_periods == 4'd0) ? 4'd1 : num_periods;
                cnt_nx   = '0;
            end
            WAIT_EDGE: begin
                cnt_nx = cnt_inc;
                if (rise) begin
                    state_nx = MEASURE;
                    cnt_nx   = '0;
                    hi_nx    = '0;
                    seen_nx  = '0;
                end else if (cnt == MAX_M1) begin
                    state_nx  = DONE;
                    err_nx    = 1'b1;
                    period_nx = MAX;
                    high_nx   = '0;
                end
            end
            MEASURE: begin
                cnt_nx  = cnt_inc;
                hi_nx   = hi_s;
                seen_nx = rise ? seen + 4'd1 : seen;
                // completion wins over overflow when both land on the same cycle
                if (rise && seen + 4'd1 == n) begin
                    state_nx  = DONE;
                    period_nx = cnt_inc;
                    high_nx   = hi_s;
                    err_nx    = 1'b0;
                end else if (cnt == MAX_M1) begin
                    state_nx  = DONE;
                    err_nx    = 1'b1;
                    period_nx = MAX;
                    high_nx   = hi_s;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: randomized scoreboard bench; expected results come from the
// generated waveform's period/high-time, independently of the meter's internals.
module tb_clk_period_meter;
    localparam int W    = 8;
    localparam int MAXV = 255;

    logic         clk = 1'b0, rst_n = 1'b0, sig_in = 1'b0, start = 1'b0;
    logic [3:0]   num_periods = '0;
    logic         busy, valid, err;
    logic [W-1:0] period_cnt, high_cnt;

    clk_period_meter #(.CNT_W(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start),
        .num_periods(num_periods), .busy(busy), .valid(valid),
        .period_cnt(period_cnt), .high_cnt(high_cnt), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {int period; int hi_min; int hi_max; bit err;} exp_t;
    exp_t sb[$];
    int   vectors = 0, miscompares = 0;

    task automatic chk(input string name, input int act, input int lo, input int hi);
        vectors++;
        if (act < lo || act > hi) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    // waveform generator: periodic p/h pattern, stuck level, or 1.5-cycle div-by-3
    int gen_p = 0, gen_h = 0, phase = 0;
    bit gen_lvl = 1'b0, gen_div3 = 1'b0;
    initial forever begin
        if (gen_div3) begin
            #2 sig_in = 1'b1;
            #15 sig_in = 1'b0;
            #13;
        end else begin
            @(negedge clk);
            if (gen_p == 0) sig_in = gen_lvl;
            else begin
                phase  = (phase + 1) % gen_p;
                sig_in = phase < gen_h;
            end
        end
    end

    int   held_p = 0, held_h = 0, held_e = 0;
    exp_t em;
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("busy", int'(busy), sb.size() != 0, sb.size() != 0);
            if (valid) begin
                if (sb.size() == 0) chk("unexpected_valid", 1, 0, 0);
                else begin
                    em = sb.pop_front();
                    chk("period_cnt", int'(period_cnt), em.period, em.period);
                    chk("high_cnt", int'(high_cnt), em.hi_min, em.hi_max);
                    chk("err", int'(err), int'(em.err), int'(em.err));
                end
                held_p = int'(period_cnt);
                held_h = int'(high_cnt);
                held_e = int'(err);
            end else begin
                chk("hold_period", int'(period_cnt), held_p, held_p);
                chk("hold_high", int'(high_cnt), held_h, held_h);
                chk("hold_err", int'(err), held_e, held_e);
            end
        end else begin
            held_p = 0;
            held_h = 0;
            held_e = 0;
        end
    end

    task automatic issue(input int p, input int h, input int n, input bit lvl, input bit div3);
        exp_t e;
        int   neff, len, cnt;
        gen_div3 = div3;
        gen_p    = div3 ? 0 : p;
        gen_h    = h;
        gen_lvl  = lvl;
        repeat (2 * p + 12) @(negedge clk);
        neff = (n == 0) ? 1 : n;
        if (div3) e = '{3 * neff, neff, 2 * neff, 1'b0};
        else if (p == 0) e = '{MAXV, 0, 0, 1'b1};
        else begin
            len = (neff * p > MAXV) ? MAXV : neff * p;
            cnt = 0;
            for (int k = 1; k <= len; k++) if (k % p < h) cnt++;
            e = '{len, cnt, cnt, neff * p > MAXV};
        end
        @(negedge clk);
        num_periods = n[3:0];
        start       = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start       = 1'b0;
        num_periods = 4'($urandom);
    endtask

    task automatic measure(input int p, input int h, input int n, input bit lvl,
                           input bit div3, input bit poke, output int lat);
        issue(p, h, n, lvl, div3);
        lat = 1;
        if (poke) begin
            @(negedge clk);
            start       = 1'b1;
            num_periods = 4'($urandom);
            @(negedge clk);
            start = 1'b0;
            lat   = 3;
        end
        while (valid !== 1'b1 && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 1000) chk("valid_seen", 0, 1, 1);
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    int lat, rp, rh;
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0, 0);
        chk("rst_valid", int'(valid), 0, 0);
        chk("rst_period", int'(period_cnt), 0, 0);
        chk("rst_high", int'(high_cnt), 0, 0);
        chk("rst_err", int'(err), 0, 0);
        #2 rst_n = 1'b1;

        measure(4, 2, 1, 0, 0, 0, lat);
        measure(6, 3, 4, 0, 0, 0, lat);
        measure(0, 0, 1, 0, 0, 0, lat);
        chk("timeout_latency_lo", lat, 256, 256);
        measure(4, 2, 0, 0, 0, 1, lat);
        measure(3, 0, 8, 0, 1, 0, lat);
        measure(0, 0, 3, 1, 0, 0, lat);
        chk("timeout_latency_hi", lat, 256, 256);
        measure(40, 13, 15, 0, 0, 0, lat);

        issue(10, 5, 8, 0, 0);
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0, 0);
        chk("midrst_valid", int'(valid), 0, 0);
        chk("midrst_period", int'(period_cnt), 0, 0);
        chk("midrst_high", int'(high_cnt), 0, 0);
        chk("midrst_err", int'(err), 0, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (100) @(negedge clk);
        measure(4, 2, 1, 0, 0, 0, lat);

        for (int i = 0; i < 20; i++) begin
            rp = $urandom_range(40, 2);
            rh = $urandom_range(rp - 1, 1);
            measure(rp, rh, int'($urandom_range(15, 0)), 0, 0, 1'($urandom), lat);
        end
        repeat (5) @(negedge clk);
        chk("queue_drained", sb.size(), 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
